token_fifo_drain: RTL and testbench

//  Consumer-side engine for dataless (token) FIFOs with an EMPTY_N/DEQ dequeue port.

---
 rtl/token_fifo_drain_pkg.sv | 14 +
 rtl/token_fifo_drain_wdog.sv | 28 ++
 rtl/token_fifo_drain.sv | 130 +++++++++++++
 tb/tb_token_fifo_drain.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/token_fifo_drain_pkg.sv
// Shared encodings for the token FIFO drain engine: FSM states and response flag layout.
package token_fifo_drain_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      RESP  = 2'd2
   } drain_state_t;

   localparam int FLG_TIMEOUT = 0;
   localparam int FLG_ABORTED = 1;
   localparam int FLG_W       = 2;

endpackage

// File: rtl/token_fifo_drain_wdog.sv
// Inactivity watchdog: counts consecutive no-token cycles, flags the last one before timeout.
module token_fifo_drain_wdog #(
   parameter int TW      = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic CLK,
   input  logic RST,
   input  logic en,
   input  logic clr,
   input  logic inc,
   output logic terminal
);

   localparam logic [TW-1:0] TERM_VAL = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [TW-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (RST || clr)
         cnt <= '0;
      else if (en && inc && !terminal)
         cnt <= cnt + 1'b1;
   end

   // TIMEOUT==0 disables the watchdog entirely
   assign terminal = (TIMEOUT != 0) && en && (cnt == TERM_VAL);

endmodule

// File: rtl/token_fifo_drain.sv
// Consumer-side drain engine: dequeues N dataless tokens per command, reports count and end cause.
module token_fifo_drain
   import token_fifo_drain_pkg::*;
#(
   parameter int CW      = 16,
   parameter int TW      = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CMD_VALID,
   output logic          CMD_READY,
   input  logic [CW-1:0] CMD_COUNT,
   input  logic          CMD_ABORT,
   input  logic          EMPTY_N,
   output logic          DEQ,
   output logic          RSP_VALID,
   input  logic          RSP_READY,
   output logic [CW-1:0] RSP_COUNT,
   output logic          RSP_TIMEOUT,
   output logic          RSP_ABORTED,
   output logic          BUSY
);

   drain_state_t      state, state_nxt;
   logic [CW-1:0]     remaining, remaining_nxt;
   logic [CW-1:0]     rsp_count, rsp_count_nxt;
   logic [FLG_W-1:0]  rsp_flags, rsp_flags_nxt;
   logic              cmd_acc;
   logic              wdog_clr, wdog_inc, wdog_term;

   assign cmd_acc   = CMD_VALID && CMD_READY;
   assign CMD_READY = (state == IDLE) && !RST;
   // Abort suppresses the dequeue even when it coincides with the last token
   assign DEQ       = (state == DRAIN) && EMPTY_N && (remaining != '0) && !CMD_ABORT && !RST;

   token_fifo_drain_wdog #(
      .TW      (TW),
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .CLK      (CLK),
      .RST      (RST),
      .en       (state == DRAIN),
      .clr      (wdog_clr),
      .inc      (wdog_inc),
      .terminal (wdog_term)
   );

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      rsp_count_nxt = rsp_count;
      rsp_flags_nxt = rsp_flags;
      wdog_clr      = 1'b0;
      wdog_inc      = 1'b0;
      unique case (state)
         IDLE: begin
            if (cmd_acc) begin
               remaining_nxt = CMD_COUNT;
               rsp_count_nxt = '0;
               rsp_flags_nxt = '0;
               wdog_clr      = 1'b1;
               state_nxt     = (CMD_COUNT == '0) ? RESP : DRAIN;
            end
         end
         DRAIN: begin
            if (CMD_ABORT) begin
               rsp_flags_nxt[FLG_ABORTED] = 1'b1;
               state_nxt                  = RESP;
            end else if (DEQ) begin
               remaining_nxt = remaining - 1'b1;
               rsp_count_nxt = rsp_count + 1'b1;
               wdog_clr      = 1'b1;
               if (remaining == CW'(1))
                  state_nxt = RESP;
            end else if (wdog_term) begin
               rsp_flags_nxt[FLG_TIMEOUT] = 1'b1;
               state_nxt                  = RESP;
            end else begin
               wdog_inc = 1'b1;
            end
         end
         RESP: begin
            if (RSP_READY)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         remaining <= '0;
         rsp_count <= '0;
         rsp_flags <= '0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         rsp_count <= rsp_count_nxt;
         rsp_flags <= rsp_flags_nxt;
      end
   end

   assign RSP_VALID   = (state == RESP);
   assign RSP_COUNT   = rsp_count;
   assign RSP_TIMEOUT = rsp_flags[FLG_TIMEOUT];
   assign RSP_ABORTED = rsp_flags[FLG_ABORTED];
   assign BUSY        = (state != IDLE);

`ifndef SYNTHESIS
   logic          chk_pend;
   logic [CW-1:0] chk_count;

   always_ff @(posedge CLK) begin
      if (RST) begin
         chk_pend  <= 1'b0;
         chk_count <= '0;
      end else begin
         if (DEQ && !EMPTY_N)
            $warning("token_fifo_drain: DEQ asserted with EMPTY_N low");
         if (CMD_VALID && !CMD_READY && chk_pend && (CMD_COUNT != chk_count))
            $warning("token_fifo_drain: CMD_COUNT changed while command stalled");
         chk_pend  <= CMD_VALID && !CMD_READY;
         chk_count <= CMD_COUNT;
      end
   end
`endif

endmodule

// File: tb/tb_token_fifo_drain.sv
// Directed bench for token_fifo_drain with TIMEOUT=8; inputs change after negedge, outputs checked 1ns later.
module tb_token_fifo_drain;

   localparam int CW = 16;
   localparam int TW = 16;

   logic          CLK = 1'b0;
   logic          RST;
   logic          CMD_VALID, CMD_READY, CMD_ABORT;
   logic [CW-1:0] CMD_COUNT;
   logic          EMPTY_N, DEQ;
   logic          RSP_VALID, RSP_READY, RSP_TIMEOUT, RSP_ABORTED, BUSY;
   logic [CW-1:0] RSP_COUNT;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   token_fifo_drain #(.CW(CW), .TW(TW), .TIMEOUT(8)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .CMD_VALID   (CMD_VALID),
      .CMD_READY   (CMD_READY),
      .CMD_COUNT   (CMD_COUNT),
      .CMD_ABORT   (CMD_ABORT),
      .EMPTY_N     (EMPTY_N),
      .DEQ         (DEQ),
      .RSP_VALID   (RSP_VALID),
      .RSP_READY   (RSP_READY),
      .RSP_COUNT   (RSP_COUNT),
      .RSP_TIMEOUT (RSP_TIMEOUT),
      .RSP_ABORTED (RSP_ABORTED),
      .BUSY        (BUSY)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge CLK);
   endtask

   task automatic chk_rsp(input string tag, input int cnt, input logic tmo, input logic abt);
      chk({tag, "_valid"}, RSP_VALID, 1);
      chk({tag, "_count"}, RSP_COUNT, cnt);
      chk({tag, "_tmo"}, RSP_TIMEOUT, tmo);
      chk({tag, "_abt"}, RSP_ABORTED, abt);
      chk({tag, "_deq"}, DEQ, 0);
   endtask

   // Called 1ns after a negedge: ack the response, confirm return to IDLE next cycle
   task automatic ack(input string tag);
      RSP_READY = 1'b1;
      nxt();
      RSP_READY = 1'b0;
      #1;
      chk({tag, "_ack_vld"}, RSP_VALID, 0);
      chk({tag, "_ack_rdy"}, CMD_READY, 1);
      chk({tag, "_ack_busy"}, BUSY, 0);
   endtask

   // Offer a command; the following posedge accepts it
   task automatic issue(input string tag, input int cnt);
      CMD_VALID = 1'b1;
      CMD_COUNT = CW'(cnt);
      #1;
      chk({tag, "_cmd_rdy"}, CMD_READY, 1);
      nxt();
      CMD_VALID = 1'b0;
   endtask

   initial begin
      RST = 1'b1; CMD_VALID = 1'b0; CMD_COUNT = '0; CMD_ABORT = 1'b0;
      EMPTY_N = 1'b1; RSP_READY = 1'b0;

      // Reset state
      nxt(); nxt(); #1;
      chk("rst_cmd_rdy", CMD_READY, 0);
      chk("rst_deq", DEQ, 0);
      chk("rst_rsp_vld", RSP_VALID, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_count", RSP_COUNT, 0);
      chk("rst_flags", {RSP_TIMEOUT, RSP_ABORTED}, 0);
      nxt(); RST = 1'b0; #1;
      chk("post_rst_rdy", CMD_READY, 1);

      // 1: four back-to-back tokens
      nxt();
      issue("t1", 4);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("t1_deq%0d", i), DEQ, 1);
         chk($sformatf("t1_busy%0d", i), BUSY, 1);
         chk($sformatf("t1_novld%0d", i), RSP_VALID, 0);
         nxt();
      end
      #1;
      chk_rsp("t1", 4, 0, 0);
      ack("t1");

      // 2: zero-count command, response held under backpressure
      nxt();
      issue("t2", 0);
      #1;
      chk_rsp("t2", 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         nxt(); #1;
         chk($sformatf("t2_hold_vld%0d", i), RSP_VALID, 1);
         chk($sformatf("t2_hold_cnt%0d", i), RSP_COUNT, 0);
         chk($sformatf("t2_hold_rdy%0d", i), CMD_READY, 0);
         chk($sformatf("t2_hold_deq%0d", i), DEQ, 0);
      end
      ack("t2");

      // 3: two tokens then starvation -> timeout after 8 idle cycles
      nxt();
      issue("t3", 5);
      #1; chk("t3_deq0", DEQ, 1);
      nxt(); #1; chk("t3_deq1", DEQ, 1);
      nxt();
      EMPTY_N = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("t3_idle_deq%0d", i), DEQ, 0);
         chk($sformatf("t3_idle_vld%0d", i), RSP_VALID, 0);
         nxt();
      end
      #1;
      chk_rsp("t3", 2, 1, 0);
      EMPTY_N = 1'b1;
      ack("t3");

      // 4: abort after three tokens
      nxt();
      issue("t4", 10);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("t4_deq%0d", i), DEQ, 1);
         nxt();
      end
      CMD_ABORT = 1'b1;
      #1;
      chk("t4_abort_deq", DEQ, 0);
      nxt();
      CMD_ABORT = 1'b0;
      #1;
      chk_rsp("t4", 3, 0, 1);
      ack("t4");

      // 5: token arrives exactly on the terminal watchdog cycle
      nxt();
      EMPTY_N = 1'b0;
      issue("t5", 2);
      for (int i = 0; i < 7; i++) begin
         #1;
         chk($sformatf("t5_wait_deq%0d", i), DEQ, 0);
         nxt();
      end
      EMPTY_N = 1'b1;
      #1;
      chk("t5_late_deq", DEQ, 1);
      nxt();
      EMPTY_N = 1'b0;
      #1;
      chk("t5_no_tmo_vld", RSP_VALID, 0);
      chk("t5_still_busy", BUSY, 1);
      chk("t5_gap_deq", DEQ, 0);
      nxt();
      EMPTY_N = 1'b1;
      #1;
      chk("t5_last_deq", DEQ, 1);
      nxt(); #1;
      chk_rsp("t5", 2, 0, 0);
      ack("t5");

      // 6: reset mid-drain discards the command, next command is normal
      nxt();
      issue("t6", 6);
      #1; chk("t6_deq0", DEQ, 1);
      nxt(); #1; chk("t6_deq1", DEQ, 1);
      nxt();
      RST = 1'b1;
      #1;
      chk("t6_rst_deq", DEQ, 0);
      chk("t6_rst_rdy", CMD_READY, 0);
      nxt();
      RST = 1'b0;
      #1;
      chk("t6_idle_busy", BUSY, 0);
      chk("t6_idle_vld", RSP_VALID, 0);
      chk("t6_idle_deq", DEQ, 0);
      chk("t6_idle_cnt", RSP_COUNT, 0);
      nxt();
      issue("t6b", 1);
      #1; chk("t6b_deq", DEQ, 1);
      nxt(); #1;
      chk_rsp("t6b", 1, 0, 0);
      ack("t6b");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
